// File: rtl/ndev_led_serial_tx.sv
// NDEV_LED debug-port serial framing transmitter: takes bytes over valid/ready and
// plays the 0x0F/0x8F preamble, per-bit low/high codes and 0x8F commit onto DEBUG_OUT.
module ndev_led_serial_tx #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter logic [7:0]  IDLE_CODE   = 8'h00
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        tx_valid,
    input  logic [7:0]  tx_data,
    output logic        tx_ready,
    input  logic        session_restart,
    output logic [7:0]  DEBUG_OUT,
    output logic        busy,
    output logic [15:0] bytes_sent
);

    localparam int unsigned CW = $clog2(HOLD_CYCLES + 1);

    if (HOLD_CYCLES == 0 || IDLE_CODE[7]) begin : g_bad_params
        $error("ndev_led_serial_tx: HOLD_CYCLES must be >= 1 and IDLE_CODE[7] must be 0");
    end

    typedef enum logic [2:0] {
        StIdle,
        StPre0,
        StPre1,
        StBitLo,
        StBitHi,
        StCommit
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] phase_q, phase_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    code_q, code_d;
    logic [15:0]   bytes_sent_q, bytes_sent_d;
    logic          need_pre_q, need_pre_d;
    logic          hold_done;
    logic          pre_done;
    logic [1:0]    rst_sync_q;
    logic          rst_int_n;

    // Reset asserts asynchronously but releases only after two clean clock edges.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_q[1];
    assign hold_done = (phase_q == CW'(HOLD_CYCLES - 1));

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        bytes_sent_d = bytes_sent_q;
        pre_done     = 1'b0;

        if (state_q != StIdle) begin
            phase_d = hold_done ? '0 : phase_q + CW'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (tx_valid) begin
                    shift_d   = tx_data;
                    bit_idx_d = 3'd7;
                    phase_d   = '0;
                    state_d   = (need_pre_q || session_restart) ? StPre0 : StBitLo;
                end
            end
            StPre0: begin
                if (hold_done) state_d = StPre1;
            end
            StPre1: begin
                if (hold_done) begin
                    state_d  = StBitLo;
                    pre_done = 1'b1;
                end
            end
            StBitLo: begin
                if (hold_done) state_d = StBitHi;
            end
            StBitHi: begin
                if (hold_done) begin
                    shift_d = {shift_q[6:0], 1'b0};
                    if (bit_idx_q == 3'd0) begin
                        state_d = StCommit;
                    end else begin
                        bit_idx_d = bit_idx_q - 3'd1;
                        state_d   = StBitLo;
                    end
                end
            end
            StCommit: begin
                if (hold_done) begin
                    state_d      = StIdle;
                    bytes_sent_d = bytes_sent_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        // A restart request wins over the clear at the end of a preamble.
        if (session_restart) begin
            need_pre_d = 1'b1;
        end else if (pre_done) begin
            need_pre_d = 1'b0;
        end else begin
            need_pre_d = need_pre_q;
        end
    end

    // Port code is derived from the next state so it is registered alongside it.
    always_comb begin
        code_d = IDLE_CODE;
        unique case (state_d)
            StIdle:   code_d = IDLE_CODE;
            StPre0:   code_d = 8'h0F;
            StPre1:   code_d = 8'h8F;
            StBitLo:  code_d = {7'b0000000, shift_d[7]};
            StBitHi:  code_d = {7'b1000000, shift_d[7]};
            StCommit: code_d = 8'h8F;
            default:  code_d = IDLE_CODE;
        endcase
    end

    always_ff @(posedge CLK or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q      <= StIdle;
            phase_q      <= '0;
            bit_idx_q    <= 3'd7;
            shift_q      <= 8'h00;
            code_q       <= IDLE_CODE;
            bytes_sent_q <= 16'h0000;
            need_pre_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            code_q       <= code_d;
            bytes_sent_q <= bytes_sent_d;
            need_pre_q   <= need_pre_d;
        end
    end

    assign DEBUG_OUT  = code_q;
    assign tx_ready   = (state_q == StIdle);
    assign busy       = (state_q != StIdle);
    assign bytes_sent = bytes_sent_q;

endmodule

// File: tb/tb_ndev_led_serial_tx.sv
// Bench for ndev_led_serial_tx: queue-based frame model checked every cycle, literal
// frame pins, abort/restart/wrap cases and a random loopback through a decoder model.
module tb_ndev_led_serial_tx;

    localparam int unsigned H    = 2;
    localparam logic [7:0]  IDLE = 8'h00;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        tx_valid = 1'b0;
    logic [7:0]  tx_data = 8'h00;
    logic        session_restart = 1'b0;
    logic        tx_ready;
    logic [7:0]  DEBUG_OUT;
    logic        busy;
    logic [15:0] bytes_sent;

    ndev_led_serial_tx #(
        .HOLD_CYCLES(H),
        .IDLE_CODE  (IDLE)
    ) dut (
        .CLK            (CLK),
        .RST_N          (RST_N),
        .tx_valid       (tx_valid),
        .tx_data        (tx_data),
        .tx_ready       (tx_ready),
        .session_restart(session_restart),
        .DEBUG_OUT      (DEBUG_OUT),
        .busy           (busy),
        .bytes_sent     (bytes_sent)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: the whole frame of an accepted byte is queued, one entry per cycle.
    typedef struct packed {
        logic [7:0] code;
        logic       end_pre;
        logic       end_commit;
    } ent_t;

    ent_t        q[$];
    bit          m_need_pre = 1'b1;
    logic [15:0] m_cnt = 16'h0000;
    int          m_accepts = 0;
    logic [7:0]  sent_q[$];

    function automatic void push_code(input logic [7:0] c, input bit ep, input bit ec);
        ent_t e;
        for (int i = 0; i < int'(H); i++) begin
            e.code       = c;
            e.end_pre    = ep && (i == int'(H) - 1);
            e.end_commit = ec && (i == int'(H) - 1);
            q.push_back(e);
        end
    endfunction

    function automatic void push_frame(input logic [7:0] d, input bit pre);
        if (pre) begin
            push_code(8'h0F, 1'b0, 1'b0);
            push_code(8'h8F, 1'b1, 1'b0);
        end
        for (int b = 7; b >= 0; b--) begin
            push_code({7'b0000000, d[b]}, 1'b0, 1'b0);
            push_code({7'b1000000, d[b]}, 1'b0, 1'b0);
        end
        push_code(8'h8F, 1'b0, 1'b1);
    endfunction

    initial forever begin
        ent_t e;
        bit   was_empty;
        @(posedge CLK or negedge RST_N);
        if (!RST_N) begin
            q.delete();
            m_need_pre = 1'b1;
            m_cnt      = 16'h0000;
        end else begin
            was_empty = (q.size() == 0);
            if (!was_empty) begin
                e = q.pop_front();
                if (e.end_pre) m_need_pre = 1'b0;
                if (e.end_commit) m_cnt = m_cnt + 16'd1;
            end
            if (was_empty && tx_valid) begin
                push_frame(tx_data, m_need_pre || session_restart);
                m_accepts++;
                sent_q.push_back(tx_data);
            end
            if (session_restart) m_need_pre = 1'b1;
        end
    end

    // Loopback decoder model: acts on code changes and bit7 rising edges.
    bit         dec_en = 1'b0;
    logic [7:0] d_prev = 8'h00;
    bit         d_serial = 1'b0;
    int         d_nbits = 0;
    logic [7:0] d_shift = 8'h00;
    int         d_false = 0;
    int         d_decoded = 0;

    initial forever begin
        logic [7:0] exp_code;
        logic [7:0] cur;
        @(negedge CLK);
        exp_code = (q.size() != 0) ? q[0].code : IDLE;
        check("debug_out", 32'(DEBUG_OUT), 32'(exp_code));
        check("tx_ready", 32'(tx_ready), 32'(q.size() == 0));
        check("busy", 32'(busy), 32'(q.size() != 0));
        check("bytes_sent", 32'(bytes_sent), 32'(m_cnt));
        if (dec_en) begin
            cur = DEBUG_OUT;
            if (cur == 8'h88 || cur == 8'h25) d_false++;
            if (cur != d_prev) begin
                if (cur == 8'h8F && d_prev == 8'h0F) begin
                    d_serial = 1'b1;
                    d_nbits  = 0;
                end else if (cur == 8'h8F && d_prev[7] && d_serial && d_nbits == 8) begin
                    if (sent_q.size() == 0) d_false++;
                    else check("loopback_byte", 32'(d_shift), 32'(sent_q.pop_front()));
                    d_decoded++;
                    d_nbits = 0;
                end else if (cur[7] && !d_prev[7] && cur[6:1] == 6'd0 &&
                             d_prev == {1'b0, cur[6:0]} && d_serial && d_nbits < 8) begin
                    d_shift = {d_shift[6:0], cur[0]};
                    d_nbits++;
                end else if (cur[7]) begin
                    d_false++;
                end
                d_prev = cur;
            end
        end
    end

    task automatic send(input logic [7:0] d);
        int t = 0;
        tx_valid = 1'b1;
        tx_data  = d;
        while (!tx_ready && t < 200) begin
            @(negedge CLK);
            t++;
        end
        check("send_accept_timeout", 32'(t < 200), 32'd1);
        @(negedge CLK);
        tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (!tx_ready && t < 200) begin
            @(negedge CLK);
            t++;
        end
        check("idle_timeout", 32'(t < 200), 32'd1);
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        repeat (4) @(negedge CLK);
    endtask

    logic [7:0] a5_codes[19] = '{8'h0F, 8'h8F, 8'h01, 8'h81, 8'h00, 8'h80, 8'h01, 8'h81,
                                 8'h00, 8'h80, 8'h00, 8'h80, 8'h01, 8'h81, 8'h00, 8'h80,
                                 8'h01, 8'h81, 8'h8F};

    initial begin
        int         low;
        int         rdy;
        int         base;
        logic [7:0] exp;

        repeat (2) @(negedge CLK);
        check("reset_debug_out", 32'(DEBUG_OUT), 32'h00);
        check("reset_tx_ready", 32'(tx_ready), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_bytes_sent", 32'(bytes_sent), 32'd0);
        RST_N = 1'b1;
        repeat (4) @(negedge CLK);

        // 0xA5 after reset carries the preamble; 19 codes, 2 cycles each.
        send(8'hA5);
        low = 0;
        for (int i = 0; i < 38; i++) begin
            check("a5_code", 32'(DEBUG_OUT), 32'(a5_codes[i / 2]));
            if (!tx_ready) low++;
            @(negedge CLK);
        end
        check("a5_ready_low_cycles", 32'(low), 32'd38);
        check("a5_then_idle_code", 32'(DEBUG_OUT), 32'h00);
        check("a5_bytes_sent", 32'(bytes_sent), 32'd1);

        // Back-to-back 0x00, 0xFF with tx_valid held throughout.
        tx_valid = 1'b1;
        tx_data  = 8'h00;
        @(negedge CLK);
        tx_data = 8'hFF;
        rdy = 0;
        for (int i = 0; i < 69; i++) begin
            if (i < 32)      exp = (i % 4 < 2) ? 8'h00 : 8'h80;
            else if (i < 34) exp = 8'h8F;
            else if (i == 34) exp = 8'h00;
            else if (i < 67) exp = ((i - 35) % 4 < 2) ? 8'h01 : 8'h81;
            else             exp = 8'h8F;
            check("b2b_code", 32'(DEBUG_OUT), 32'(exp));
            if (tx_ready) rdy++;
            @(negedge CLK);
            if (i == 34) tx_valid = 1'b0;
        end
        check("b2b_single_idle_cycle", 32'(rdy), 32'd1);
        check("b2b_bytes_sent", 32'(bytes_sent), 32'd3);

        // Restart mid-byte leaves 0x3C untouched; 0x12 then opens with the preamble.
        send(8'h3C);
        check("3c_no_preamble", 32'(DEBUG_OUT), 32'h00);
        repeat (10) @(negedge CLK);
        session_restart = 1'b1;
        @(negedge CLK);
        session_restart = 1'b0;
        wait_idle();
        send(8'h12);
        check("restart_preamble", 32'(DEBUG_OUT), 32'h0F);
        wait_idle();
        check("restart_bytes_sent", 32'(bytes_sent), 32'd5);

        // Abort during BIT_HI of bit 4 of 0xB4.
        send(8'hB4);
        repeat (14) @(negedge CLK);
        check("abort_at_bit4_hi", 32'(DEBUG_OUT), 32'h81);
        #2 RST_N = 1'b0;
        #1;
        check("abort_debug_out", 32'(DEBUG_OUT), 32'h00);
        check("abort_tx_ready", 32'(tx_ready), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_bytes_sent", 32'(bytes_sent), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (4) @(negedge CLK);
        send(8'h5A);
        check("post_abort_preamble", 32'(DEBUG_OUT), 32'h0F);
        wait_idle();
        check("post_abort_bytes_sent", 32'(bytes_sent), 32'd1);

        // Counter wrap.
        #1;
        force dut.bytes_sent_q = 16'hFFFF;
        m_cnt = 16'hFFFF;
        @(negedge CLK);
        #1;
        release dut.bytes_sent_q;
        @(negedge CLK);
        send(8'h77);
        wait_idle();
        check("wrap_bytes_sent", 32'(bytes_sent), 32'h0000);

        // Random loopback through the decoder model.
        do_reset();
        sent_q.delete();
        d_prev    = DEBUG_OUT;
        d_serial  = 1'b0;
        d_nbits   = 0;
        d_false   = 0;
        d_decoded = 0;
        base      = m_accepts;
        dec_en    = 1'b1;
        for (int cyc = 0; cyc < 40000 && (m_accepts - base) < 256; cyc++) begin
            tx_valid        = ($urandom_range(0, 2) == 0);
            tx_data         = 8'($urandom);
            session_restart = ($urandom_range(0, 63) == 0);
            @(negedge CLK);
        end
        tx_valid        = 1'b0;
        session_restart = 1'b0;
        check("loopback_accepts", 32'(m_accepts - base), 32'd256);
        wait_idle();
        repeat (2) @(negedge CLK);
        check("loopback_decoded", 32'(d_decoded), 32'd256);
        check("loopback_false_triggers", 32'(d_false), 32'd0);
        check("loopback_drained", 32'(sent_q.size()), 32'd0);
        dec_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
